// File: rtl/ascii_7seg_pkg.sv
// Shared constants, types and helpers for the ASCII 7-segment scan display.
package ascii_7seg_pkg;

  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  // Segment order is {a,b,c,d,e,f,g}; 1 = segment lit.
  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_BLANK      = 7'b000_0000;
  localparam seg_pattern_t SEG_UNDERSCORE = 7'b000_1000;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX);
  endfunction

endpackage

// File: rtl/ascii_seg_decoder.sv
// Combinational ASCII to active-high abcdefg glyph decoder.
module ascii_seg_decoder
  import ascii_7seg_pkg::*;
(
  input  logic [7:0]   ascii,
  output seg_pattern_t pattern
);

  always_comb begin
    pattern = is_printable(ascii) ? SEG_UNDERSCORE : SEG_BLANK;
    case (ascii)
      8'h20: pattern = SEG_BLANK;
      8'h30: pattern = 7'b111_1110;
      8'h31: pattern = 7'b011_0000;
      8'h32: pattern = 7'b110_1101;
      8'h33: pattern = 7'b111_1001;
      8'h34: pattern = 7'b011_0011;
      8'h35: pattern = 7'b101_1011;
      8'h36: pattern = 7'b101_1111;
      8'h37: pattern = 7'b111_0000;
      8'h38: pattern = 7'b111_1111;
      8'h39: pattern = 7'b111_1011;
      8'h2D: pattern = 7'b000_0001;
      8'h40: pattern = 7'b111_1101;
      // Letters without a clean glyph in one case borrow the other case.
      8'h41, 8'h61: pattern = 7'b111_0111;
      8'h42, 8'h62: pattern = 7'b001_1111;
      8'h43, 8'h63: pattern = 7'b100_1110;
      8'h44, 8'h64: pattern = 7'b011_1101;
      8'h45, 8'h65: pattern = 7'b100_1111;
      8'h46, 8'h66: pattern = 7'b100_0111;
      8'h48, 8'h68: pattern = 7'b011_0111;
      8'h49, 8'h69: pattern = 7'b011_0000;
      8'h4A, 8'h6A: pattern = 7'b011_1000;
      8'h4C, 8'h6C: pattern = 7'b000_1110;
      8'h50, 8'h70: pattern = 7'b110_0111;
      8'h55, 8'h75: pattern = 7'b011_1110;
      8'h59, 8'h79: pattern = 7'b011_1011;
      default: ;
    endcase
  end

endmodule

// File: rtl/ascii_7seg_scan_display.sv
// Multiplexed multi-digit 7-segment driver fed by an ASCII valid/ready stream.
// Optional cursor blink on digit 0 dp: define ASCII_7SEG_CURSOR_BLINK_EN.
module ascii_7seg_scan_display
  import ascii_7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam seg_pattern_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] AN_RESET = (AN_ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);

  state_t state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic [7:0] char_buf_q [NUM_DIGITS];
  logic [7:0] char_buf_d [NUM_DIGITS];

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_pattern_t seg_q, seg_d;
  logic dp_q, dp_d;

  logic xfer;
  logic scan_wrap;
  logic [NUM_DIGITS-1:0] onehot;
  seg_pattern_t scan_pattern;

  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q == CLEAR);
  assign xfer       = char_valid && char_ready;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    char_buf_d = char_buf_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (xfer) begin
          if (is_printable(char_data)) begin
            for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
              char_buf_d[i] = char_buf_q[i-1];
            end
            char_buf_d[0] = char_data;
          end else if (char_data == ASCII_BS) begin
            for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
              char_buf_d[i] = char_buf_q[i+1];
            end
            char_buf_d[NUM_DIGITS-1] = ASCII_SPACE;
          end else if (char_data == ASCII_CR) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
          end
        end
      end
      CLEAR: begin
        char_buf_d[clr_idx_q] = ASCII_SPACE;
        clr_idx_d = clr_idx_q + IW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_wrap  = (presc_q == LAST_PRESC);
    presc_d    = scan_wrap ? '0 : presc_q + PW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_wrap) begin
      scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IW'(1);
    end
  end

  ascii_seg_decoder u_dec (
    .ascii   (char_buf_q[scan_idx_q]),
    .pattern (scan_pattern)
  );

  // Outputs are registered from the current index so an/seg/dp switch together.
  always_comb begin
    onehot             = '0;
    onehot[scan_idx_q] = 1'b1;
    an_d  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~scan_pattern : scan_pattern;
  end

`ifdef ASCII_7SEG_CURSOR_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       cursor_q, cursor_d;
  logic       frame_wrap;

  always_comb begin
    frame_wrap  = scan_wrap && (scan_idx_q == LAST_IDX);
    blink_cnt_d = blink_cnt_q;
    cursor_d    = cursor_q;
    if (xfer) begin
      blink_cnt_d = '0;
      cursor_d    = 1'b1;
    end else if (frame_wrap) begin
      blink_cnt_d = blink_cnt_q + 8'd1;
      if (blink_cnt_q == 8'hFF) begin
        cursor_d = ~cursor_q;
      end
    end
    dp_d = DP_OFF;
    if ((scan_idx_q == '0) && cursor_q) begin
      dp_d = ~DP_OFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      cursor_q    <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      cursor_q    <= cursor_d;
    end
  end
`else
  always_comb begin
    dp_d = DP_OFF;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      char_buf_q <= '{default: ASCII_SPACE};
      presc_q    <= '0;
      scan_idx_q <= '0;
      an_q       <= AN_RESET;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      char_buf_q <= char_buf_d;
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

endmodule

// File: doc/ascii_7seg_scan_display.md
Name: ascii_7seg_scan_display

Overview:
Multi-digit, time-multiplexed 7-segment display driver for the MIPS_UART board.
- Accepts ASCII characters one at a time over a valid/ready handshake, typically from the UART RX path or a memory-mapped port.
- Stores the characters in a shift buffer of NUM_DIGITS entries.
- Scans the digits onto one shared segment bus with a common-anode enable vector.
- Handles backspace and carriage-return control codes.

Parameters:
- NUM_DIGITS, 4: number of display digits; legal range 2..8.
- SCAN_DIV, 50000: clk cycles each digit stays enabled; minimum 2.
- SEG_ACTIVE_LOW, 1: 1 drives seg/dp active-low; 0 drives them active-high.
- AN_ACTIVE_LOW, 1: 1 drives an active-low; 0 drives it active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- char_valid  input  1  char_data is valid this cycle.
- char_data  input  8  ASCII code.
- char_ready  output  1  block accepts char_data this cycle.
- clear  input  1  single-cycle request to blank the whole buffer.
- seg  output  7  {a,b,c,d,e,f,g} for the currently scanned digit.
- dp  output  1  decimal point for the currently scanned digit.
- an  output  NUM_DIGITS  one-hot digit enable.
- busy  output  1  high while in the CLEAR state.

Behaviour:
- Reset values:
  - Every buffer entry is 0x20 (space).
  - State is IDLE, char_ready=1, busy=0.
  - Scan index is 0 and the prescaler is 0.
  - an enables digit 0; seg and dp are all segments off, at the polarity set by the parameters.
- Handshake:
  - A transfer occurs when char_valid && char_ready, sampled on the rising edge of clk.
  - char_ready=1 only in IDLE.
  - char_data is ignored when no transfer occurs.
- State machine (IDLE, CLEAR):
  - IDLE, printable transfer (0x20..0x7E): buf[i] <= buf[i-1] for i>0, and buf[0] <= char_data. Digit 0 is the rightmost digit. Stays in IDLE; one character per cycle is sustainable.
  - IDLE, 0x08 (backspace) transfer: buf[i] <= buf[i+1], and buf[NUM_DIGITS-1] <= 0x20. Stays in IDLE.
  - IDLE, 0x0D transfer, or clear=1: go to CLEAR and load clr_idx=0.
  - CLEAR: writes buf[clr_idx] <= 0x20 each cycle and increments clr_idx. After writing index NUM_DIGITS-1 it returns to IDLE. CLEAR lasts exactly NUM_DIGITS cycles; char_ready=0 and busy=1 for that whole time.
  - Other codes (0x00..0x1F except 0x08 and 0x0D, plus 0x7F..0xFF): accepted and dropped; the buffer is unchanged.
  - clear and a transfer in the same IDLE cycle: clear wins and the character is dropped.
  - clear asserted while in CLEAR: ignored.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1.
  - On the terminal count the scan index advances and wraps from NUM_DIGITS-1 to 0.
  - an, seg and dp are registered, so they change together one cycle after the index update. There are no glitches between digits.
  - The scanner runs in every state; display content updates on the next scan of the affected digit.
- Decode (abcdefg, 1 = segment lit, before polarity is applied):
  - '0'..'9': standard digit patterns.
  - Supported letters: A, b, C, d, E, F, H, I, J, L, P, U, y.
  - '@' and '-' are supported.
  - Lowercase a/c/e/f/h/i/j/l/p/u map to their uppercase glyph; uppercase B/D/Y map to b/d/y.
  - 0x20 lights no segments.
  - Any other printable code shows segment d only (underscore).
- Width rules:
  - The prescaler is $clog2(SCAN_DIV) bits wide.
  - The scan index and clr_idx are max(1,$clog2(NUM_DIGITS)) bits wide.
- reset asserted mid-CLEAR or mid-scan: everything returns to the reset values immediately, asynchronously.

Optional Feature:
- Macro: ASCII_7SEG_CURSOR_BLINK_EN.
- Defined:
  - A blink counter toggles a cursor flag each time the scan index has wrapped 256 times.
  - dp for digit 0 follows the cursor flag, so the decimal point blinks at the insertion point.
  - Every transfer resets the blink counter and sets the flag on.
- Undefined:
  - No blink logic is present.
  - dp is the off level for every digit.

Decomposition:
- Package ascii_7seg_pkg holds:
  - The ASCII constants: ASCII_SPACE=8'h20, ASCII_BS=8'h08, ASCII_CR=8'h0D, ASCII_PRINT_MIN=8'h20, ASCII_PRINT_MAX=8'h7E.
  - A 7-bit seg_pattern_t typedef.
  - Named segment-pattern constants: SEG_BLANK, SEG_UNDERSCORE.
  - A state_t enum {IDLE, CLEAR}.
- Sub-module ascii_seg_decoder: purely combinational. It maps an 8-bit ASCII code to an active-high abcdefg pattern. It is instantiated once, on the scanned buffer entry; polarity inversion is applied in the parent.

Test Plan:
- Reset, then send "12AB" as four back-to-back transfers (char_ready stays 1):
  - Expect buf[3..0] = '1','2','A','B'.
  - With SCAN_DIV=4, over 16 cycles expect an to cycle 1110→1101→1011→0111, with seg matching the B, A, 2, 1 patterns.
- With buffer "12AB", send 0x08: expect buffer " 12A" and a blank digit 3.
- With buffer full, pulse clear:
  - Expect busy=1 and char_ready=0 for exactly 4 cycles.
  - A char_valid held during CLEAR is accepted only on the first IDLE cycle.
  - The buffer is all 0x20 after CLEAR.
- Send 0x0D and 0x7F:
  - 0x0D enters CLEAR.
  - 0x7F is accepted with the buffer unchanged.
  - Send 'x' (0x78): expect the underscore pattern on digit 0.
- Assert reset mid-CLEAR (cycle 2): expect an immediate return to the reset values, with all segments off.
- With ASCII_7SEG_CURSOR_BLINK_EN defined and SCAN_DIV=2, NUM_DIGITS=4:
  - Expect dp on digit 0 to toggle every 2048 cycles.
  - A transfer forces dp on.
